// File: rtl/subdiv_pkg.sv
// subdiv_pkg: definitions shared by the subdivision read-side blocks.
//   ADDR_WIDTH        - width of the neighbor/obj RAM word addresses
//   OBJ_VERTEX_OFFSET - obj RAM word address of vertex 1's x coordinate
//   gather_state_t    - neighbor_gather FSM states (also exported for debug)
//   vertex_addr()     - obj RAM address of vertex v's x word, 3*(v-1)+2
package subdiv_pkg;

    localparam int ADDR_WIDTH        = 9;
    localparam int OBJ_VERTEX_OFFSET = 2;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CNT    = 4'd1,
        ST_NIDX   = 4'd2,
        ST_X      = 4'd3,
        ST_Y      = 4'd4,
        ST_Z      = 4'd5,
        ST_SKIP   = 4'd6,
        ST_CENTER = 4'd7,
        ST_OUT    = 4'd8
    } gather_state_t;

    // Address arithmetic wraps to the RAM address width.
    function automatic logic [ADDR_WIDTH-1:0] vertex_addr(input logic [31:0] v);
        return ADDR_WIDTH'(32'd3 * (v - 32'd1) + 32'(OBJ_VERTEX_OFFSET));
    endfunction

endpackage

// File: rtl/neighbor_gather_acc.sv
// neighbor_gather_acc: three signed coordinate accumulators.
//   clk, rst          - clock, synchronous active-high reset (clears sums)
//   clr               - clear all three sums (start of a new request)
//   add_x/add_y/add_z - add the sign-extended din word into that sum
//   din               - 32-bit two's-complement coordinate word
//   sum_x/y/z         - SUM_WIDTH signed sums
module neighbor_gather_acc #(
    parameter int SUM_WIDTH = 36
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        add_x,
    input  logic                        add_y,
    input  logic                        add_z,
    input  logic [31:0]                 din,
    output logic signed [SUM_WIDTH-1:0] sum_x,
    output logic signed [SUM_WIDTH-1:0] sum_y,
    output logic signed [SUM_WIDTH-1:0] sum_z
);

    logic signed [SUM_WIDTH-1:0] din_ext;

    assign din_ext = {{(SUM_WIDTH-32){din[31]}}, din};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum_x <= '0;
            sum_y <= '0;
            sum_z <= '0;
        end else begin
            if (add_x) sum_x <= sum_x + din_ext;
            if (add_y) sum_y <= sum_y + din_ext;
            if (add_z) sum_z <= sum_z + din_ext;
        end
    end

endmodule

// File: rtl/neighbor_gather.sv
// neighbor_gather: for one requested vertex, walks its neighbor list in the
// neighbor RAM, fetches each neighbor's x/y/z from the obj RAM and returns the
// valence plus signed coordinate sums.
//
// Handshake: a request is accepted on an edge where req_valid && req_ready;
// req_ready is high only in IDLE. A response is presented with resp_valid and
// held, outputs stable, until an edge where resp_valid && resp_ready.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   vertex_count              - number of vertices in the obj RAM
//   req_valid/req_ready       - request handshake, req_vertex is 1-based
//   RAM_NBR_* / RAM_OBJ_*     - read-only RAM ports (registered addresses,
//                               data valid one edge after the address edge)
//   resp_valid/resp_ready     - response handshake
//   valence, sum_x/y/z        - neighbors summed and their coordinate sums
//   err                       - bad request vertex or a skipped neighbor index
//   ovf                       - stored count was clamped to MAX-1
//   center_x/y/z              - requested vertex's own coordinates
//                               (only with NEIGHBOR_GATHER_CENTER_EN)
//   dbg_state                 - current FSM state
//
// Build option: define NEIGHBOR_GATHER_CENTER_EN to add the CENTER state and
// the center_x/y/z outputs.
module neighbor_gather
    import subdiv_pkg::*;
#(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int SUM_WIDTH          = 36
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 vertex_count,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [31:0]                 req_vertex,
    output logic                        RAM_NBR_EN,
    output logic [ADDR_WIDTH-1:0]       RAM_NBR_A,
    output logic [3:0]                  RAM_NBR_WE,
    input  logic [31:0]                 RAM_NBR_Do,
    output logic                        RAM_OBJ_EN,
    output logic [ADDR_WIDTH-1:0]       RAM_OBJ_A,
    output logic [3:0]                  RAM_OBJ_WE,
    input  logic [31:0]                 RAM_OBJ_Do,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [3:0]                  valence,
    output logic signed [SUM_WIDTH-1:0] sum_x,
    output logic signed [SUM_WIDTH-1:0] sum_y,
    output logic signed [SUM_WIDTH-1:0] sum_z,
    output logic                        err,
    output logic                        ovf,
`ifdef NEIGHBOR_GATHER_CENTER_EN
    output logic [31:0]                 center_x,
    output logic [31:0]                 center_y,
    output logic [31:0]                 center_z,
`endif
    output gather_state_t               dbg_state
);

    localparam logic [3:0] CNT_MAX = 4'(MAX_NEIGHBOR_COUNT - 1);

`ifdef NEIGHBOR_GATHER_CENTER_EN
    localparam gather_state_t DONE_STATE = ST_CENTER;
`else
    localparam gather_state_t DONE_STATE = ST_OUT;
`endif

    function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [31:0] v);
        return ADDR_WIDTH'((v - 32'd1) * 32'(MAX_NEIGHBOR_COUNT));
    endfunction

    gather_state_t         state, state_next;
    logic [ADDR_WIDTH-1:0] nbr_base, nbr_a, obj_a;
    logic [3:0]            cnt, idx, idx_inc, raw_cnt, cnt_in;
    logic                  req_ok, nbr_ok, last_entry, start;

    assign raw_cnt    = RAM_NBR_Do[3:0];
    assign cnt_in     = (raw_cnt > CNT_MAX) ? CNT_MAX : raw_cnt;
    assign req_ok     = (req_vertex != 32'd0) && (req_vertex <= vertex_count);
    assign nbr_ok     = (RAM_NBR_Do != 32'd0) && (RAM_NBR_Do <= vertex_count);
    assign idx_inc    = idx + 4'd1;
    assign last_entry = (idx_inc == cnt);
    assign start      = (state == ST_IDLE) && req_valid;

`ifdef NEIGHBOR_GATHER_CENTER_EN
    logic [31:0] vertex;
    logic [1:0]  center_phase;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        RAM_NBR_EN = 1'b1;
        RAM_OBJ_EN = 1'b1;
        case (state)
            ST_IDLE: begin
                req_ready  = 1'b1;
                RAM_NBR_EN = 1'b0;
                RAM_OBJ_EN = 1'b0;
                if (req_valid) state_next = req_ok ? ST_CNT : ST_OUT;
            end
            ST_CNT:  state_next = (cnt_in == 4'd0) ? DONE_STATE : ST_NIDX;
            ST_NIDX: state_next = nbr_ok ? ST_X : ST_SKIP;
            ST_X:    state_next = ST_Y;
            ST_Y:    state_next = ST_Z;
            // A skipped index spends one bookkeeping cycle in SKIP doing what
            // Z does for a real neighbor, minus the sum and valence update.
            ST_Z, ST_SKIP: state_next = last_entry ? DONE_STATE : ST_NIDX;
`ifdef NEIGHBOR_GATHER_CENTER_EN
            ST_CENTER: if (center_phase == 2'd2) state_next = ST_OUT;
`endif
            ST_OUT: begin
                resp_valid = 1'b1;
                RAM_NBR_EN = 1'b0;
                RAM_OBJ_EN = 1'b0;
                if (resp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Address, count and status datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            nbr_base <= '0;
            nbr_a    <= '0;
            obj_a    <= '0;
            cnt      <= '0;
            idx      <= '0;
            valence  <= '0;
            err      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    nbr_base <= slot_base(req_vertex);
                    nbr_a    <= slot_base(req_vertex);
                    cnt      <= '0;
                    idx      <= '0;
                    valence  <= '0;
                    err      <= !req_ok;
                    ovf      <= 1'b0;
                end
                ST_CNT: begin
                    cnt <= cnt_in;
                    ovf <= (raw_cnt > CNT_MAX);
                    idx <= '0;
                    if (cnt_in != 4'd0) nbr_a <= nbr_base + ADDR_WIDTH'(1);
                end
                ST_NIDX: begin
                    if (nbr_ok) obj_a <= vertex_addr(RAM_NBR_Do);
                    else        err   <= 1'b1;
                end
                ST_X, ST_Y: obj_a <= obj_a + ADDR_WIDTH'(1);
                ST_Z, ST_SKIP: begin
                    if (state == ST_Z) valence <= valence + 4'd1;
                    idx <= idx_inc;
                    // Entry idx lives at base+1+idx; word 0 is the count.
                    if (!last_entry)
                        nbr_a <= nbr_base + ADDR_WIDTH'(1) + ADDR_WIDTH'(idx_inc);
                end
                default: ;
            endcase
`ifdef NEIGHBOR_GATHER_CENTER_EN
            if (start) vertex <= req_vertex;
            if (state_next == ST_CENTER && state != ST_CENTER)
                obj_a <= vertex_addr(vertex);
            else if (state == ST_CENTER)
                obj_a <= obj_a + ADDR_WIDTH'(1);
`endif
        end
    end

`ifdef NEIGHBOR_GATHER_CENTER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            vertex       <= '0;
            center_phase <= '0;
            center_x     <= '0;
            center_y     <= '0;
            center_z     <= '0;
        end else if (state == ST_CENTER) begin
            center_phase <= center_phase + 2'd1;
            case (center_phase)
                2'd0:    center_x <= RAM_OBJ_Do;
                2'd1:    center_y <= RAM_OBJ_Do;
                default: center_z <= RAM_OBJ_Do;
            endcase
        end else begin
            center_phase <= '0;
        end
    end
`endif

    neighbor_gather_acc #(
        .SUM_WIDTH (SUM_WIDTH)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .add_x (state == ST_X),
        .add_y (state == ST_Y),
        .add_z (state == ST_Z),
        .din   (RAM_OBJ_Do),
        .sum_x (sum_x),
        .sum_y (sum_y),
        .sum_z (sum_z)
    );

    assign RAM_NBR_A  = nbr_a;
    assign RAM_OBJ_A  = obj_a;
    assign RAM_NBR_WE = 4'b0000;
    assign RAM_OBJ_WE = 4'b0000;
    assign dbg_state  = state;

endmodule
